// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C 7-bit target responder with 8-bit register-pointer access
module i2c_target #(
  parameter logic [6:0] ADDRESS       = 7'b1101011,
  parameter int         FILTER_CYCLES = 4,
  parameter int         HOLD_CYCLES   = 15
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_write,
  output logic       reg_read,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_ADDR_ACK = 3'd2;
  localparam logic [2:0] S_WR_BYTE  = 3'd3;
  localparam logic [2:0] S_WR_ACK   = 3'd4;
  localparam logic [2:0] S_RD_BYTE  = 3'd5;
  localparam logic [2:0] S_RD_ACK   = 3'd6;
  localparam logic [2:0] S_IGNORE   = 3'd7;

  localparam logic [3:0] FILT_LAST = 4'(FILTER_CYCLES - 1);
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES);

  logic [1:0] scl_s_q, scl_s_d, sda_s_q, sda_s_d;
  logic [3:0] scl_c_q, scl_c_d, sda_c_q, sda_c_d;
  logic       scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic       scl_p_q, scl_p_d, sda_p_q, sda_p_d;
  logic [2:0] state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       write_q, write_d;
  logic       read_q, read_d;
  logic       rd_dly_q, rd_dly_d;
  logic       busy_q, busy_d;
  logic       first_q, first_d;
  logic       rw_q, rw_d;
  logic       oe_q, oe_d;
  logic       oe_pend_q, oe_pend_d;
  logic [7:0] hold_q, hold_d;

  logic       scl_rise, scl_fall, start_c, stop_c;
  logic [7:0] byte_in;

  assign sda       = oe_q ? 1'b0 : 1'bz;
  assign reg_addr  = ptr_q;
  assign reg_wdata = wdata_q;
  assign reg_write = write_q;
  assign reg_read  = read_q;
  assign busy      = busy_q;

  assign scl_rise = scl_f_q & ~scl_p_q;
  assign scl_fall = ~scl_f_q & scl_p_q;
  assign start_c  = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
  assign stop_c   = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;
  assign byte_in  = {shift_q[6:0], sda_f_q};

  // Synchronize both pins, then only accept a level after FILTER_CYCLES stable samples.
  always_comb begin
    scl_s_d = {scl_s_q[0], scl};
    sda_s_d = {sda_s_q[0], sda};
    scl_f_d = scl_f_q;
    scl_c_d = '0;
    if (scl_s_q[1] != scl_f_q) begin
      if (scl_c_q == FILT_LAST) scl_f_d = scl_s_q[1];
      else                      scl_c_d = scl_c_q + 4'd1;
    end
    sda_f_d = sda_f_q;
    sda_c_d = '0;
    if (sda_s_q[1] != sda_f_q) begin
      if (sda_c_q == FILT_LAST) sda_f_d = sda_s_q[1];
      else                      sda_c_d = sda_c_q + 4'd1;
    end
    scl_p_d = scl_f_q;
    sda_p_d = sda_f_q;
  end

  // Protocol FSM; the SDA target is chosen at each SCL fall and applied after the hold delay.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    wdata_d   = wdata_q;
    write_d   = 1'b0;
    read_d    = 1'b0;
    rd_dly_d  = read_q;
    busy_d    = busy_q;
    first_d   = first_q;
    rw_d      = rw_q;
    oe_d      = oe_q;
    oe_pend_d = oe_pend_q;
    hold_d    = hold_q;

    if (hold_q != 8'd0) begin
      hold_d = hold_q - 8'd1;
      if (hold_q == 8'd1) oe_d = oe_pend_q;
    end
    // Read data arrives one cycle after the request strobe.
    if (rd_dly_q) tx_d = reg_rdata;
    // The pointer advances only after the write strobe has presented the old value.
    if (write_q) ptr_d = ptr_q + 8'd1;

    if (start_c) begin
      state_d   = S_ADDR;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
      hold_d    = '0;
    end else if (stop_c) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      oe_d    = 1'b0;
      hold_d  = '0;
    end else begin
      if (scl_fall) begin
        hold_d    = HOLD_LOAD;
        oe_pend_d = 1'b0;
      end
      case (state_q)
        S_ADDR: if (scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            if (byte_in[7:1] == ADDRESS) begin
              state_d = S_ADDR_ACK;
              busy_d  = 1'b1;
              rw_d    = byte_in[0];
              read_d  = byte_in[0];
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              oe_pend_d = 1'b1;
            end else if (rw_q) begin
              state_d   = S_RD_BYTE;
              bit_cnt_d = '0;
              oe_pend_d = ~tx_q[7];
            end else begin
              state_d   = S_WR_BYTE;
              bit_cnt_d = '0;
              first_d   = 1'b1;
            end
          end
        end
        S_WR_BYTE: if (scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            state_d   = S_WR_ACK;
            bit_cnt_d = '0;
            if (first_q) begin
              ptr_d   = byte_in;
              first_d = 1'b0;
            end else begin
              write_d = 1'b1;
              wdata_d = byte_in;
            end
          end
        end
        S_WR_ACK: begin
          if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              oe_pend_d = 1'b1;
            end else begin
              state_d   = S_WR_BYTE;
              bit_cnt_d = '0;
            end
          end
        end
        S_RD_BYTE: begin
          if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              oe_pend_d = ~tx_q[7];
            end else if (bit_cnt_q == 4'd8) begin
              state_d   = S_RD_ACK;
              bit_cnt_d = '0;
            end else begin
              tx_d      = {tx_q[6:0], 1'b0};
              oe_pend_d = ~tx_q[6];
            end
          end
        end
        S_RD_ACK: if (scl_rise) begin
          ptr_d = ptr_q + 8'd1;
          if (!sda_f_q) begin
            state_d   = S_RD_BYTE;
            bit_cnt_d = '0;
            read_d    = 1'b1;
          end else begin
            state_d = S_IGNORE;
            busy_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers; the bus is assumed idle-high out of reset.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      scl_s_q   <= 2'b11;
      sda_s_q   <= 2'b11;
      scl_c_q   <= '0;
      sda_c_q   <= '0;
      scl_f_q   <= 1'b1;
      sda_f_q   <= 1'b1;
      scl_p_q   <= 1'b1;
      sda_p_q   <= 1'b1;
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      ptr_q     <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      read_q    <= 1'b0;
      rd_dly_q  <= 1'b0;
      busy_q    <= 1'b0;
      first_q   <= 1'b0;
      rw_q      <= 1'b0;
      oe_q      <= 1'b0;
      oe_pend_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      scl_s_q   <= scl_s_d;
      sda_s_q   <= sda_s_d;
      scl_c_q   <= scl_c_d;
      sda_c_q   <= sda_c_d;
      scl_f_q   <= scl_f_d;
      sda_f_q   <= sda_f_d;
      scl_p_q   <= scl_p_d;
      sda_p_q   <= sda_p_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ptr_q     <= ptr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      read_q    <= read_d;
      rd_dly_q  <= rd_dly_d;
      busy_q    <= busy_d;
      first_q   <= first_d;
      rw_q      <= rw_d;
      oe_q      <= oe_d;
      oe_pend_q <= oe_pend_d;
      hold_q    <= hold_d;
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - bus-level bench for i2c_target with strobe scoreboard
module tb_i2c_target;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_o;
  logic       m_low;
  wire        sda;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_write, reg_read, busy;

  int tests  = 0;
  int failed = 0;

  logic [15:0] wr_exp[$];
  logic [7:0]  rd_exp[$];
  logic        prev_write, prev_read;

  always #5 clk = ~clk;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_target dut (
    .clk_in   (clk),
    .reset    (reset),
    .scl      (scl_o),
    .sda      (sda),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_write(reg_write),
    .reg_read (reg_read),
    .reg_rdata(reg_rdata),
    .busy     (busy)
  );

  // Register file model: synchronous read returning addr ^ 0xFF.
  always @(posedge clk) begin
    if (reset) reg_rdata <= 8'h00;
    else if (reg_read) reg_rdata <= reg_addr ^ 8'hFF;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Strobe monitor: pops expected writes/reads from the scoreboard queues.
  always @(negedge clk) begin
    prev_write <= reg_write;
    prev_read  <= reg_read;
    if (!reset) begin
      if (reg_write && reg_read) begin
        tests++; failed++;
        $display("FAIL strobe_overlap: write and read high together at addr %0h", reg_addr);
      end
      if ((reg_write && prev_write) || (reg_read && prev_read)) begin
        tests++; failed++;
        $display("FAIL strobe_width: strobe longer than one cycle at addr %0h", reg_addr);
      end
      if (reg_write) begin
        if (wr_exp.size() == 0) begin
          tests++; failed++;
          $display("FAIL unexpected_write: addr %0h data %0h with none expected", reg_addr, reg_wdata);
        end else begin
          check("write", {reg_addr, reg_wdata}, {16'h0, wr_exp.pop_front()});
        end
      end
      if (reg_read) begin
        if (rd_exp.size() == 0) begin
          tests++; failed++;
          $display("FAIL unexpected_read: addr %0h with none expected", reg_addr);
        end else begin
          check("read_addr", reg_addr, {24'h0, rd_exp.pop_front()});
        end
      end
    end
  end

  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Each bit: 40 clocks SCL low, 40 clocks SCL high; tasks start just after SCL falls.
  task automatic write_bit(input logic b);
    w(20); m_low = ~b; w(20); scl_o = 1'b1; w(40); scl_o = 1'b0;
  endtask

  task automatic read_bit(output logic b, output logic early);
    w(12); m_low = 1'b0; w(7); early = sda; w(21);
    scl_o = 1'b1; w(20); b = sda; w(20); scl_o = 1'b0;
  endtask

  task automatic do_start();
    m_low = 1'b1; w(20); scl_o = 1'b0;
  endtask

  task automatic do_rstart();
    w(12); m_low = 1'b0; w(28); scl_o = 1'b1; w(20); m_low = 1'b1; w(20); scl_o = 1'b0;
  endtask

  task automatic do_stop();
    w(20); m_low = 1'b1; w(20); scl_o = 1'b1; w(20); m_low = 1'b0; w(40);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack, output logic early);
    logic bv;
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(bv, early);
    ack = ~bv;
  endtask

  task automatic recv_byte(input logic ack_it, output logic [7:0] b);
    logic bv, e;
    for (int i = 7; i >= 0; i--) begin
      read_bit(bv, e);
      b[i] = bv;
    end
    write_bit(~ack_it);
  endtask

  typedef struct {
    logic [7:0] dev;
    logic [7:0] ptr;
    int         nd;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       exp_ack;
    logic [7:0] exp_ptr;
  } wvec_t;

  initial begin
    wvec_t      vecs[4];
    logic       ack, early;
    logic [7:0] rb, a, d;

    vecs[0] = '{8'hD6, 8'h08, 2, 8'hA5, 8'h5A, 1'b1, 8'h0A};
    vecs[1] = '{8'hD6, 8'hFF, 2, 8'h11, 8'h22, 1'b1, 8'h01};
    vecs[2] = '{8'hA0, 8'h08, 0, 8'h00, 8'h00, 1'b0, 8'h01};
    vecs[3] = '{8'hD6, 8'h30, 1, 8'h77, 8'h00, 1'b1, 8'h31};

    reset = 1'b1; scl_o = 1'b1; m_low = 1'b0;
    w(5);
    reset = 1'b0;
    w(20);
    check("rst_reg_addr", reg_addr, 8'h00);
    check("rst_reg_wdata", reg_wdata, 8'h00);
    check("rst_reg_write", reg_write, 1'b0);
    check("rst_reg_read", reg_read, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sda", sda, 1'b1);

    // Register writes, pointer wrap and address mismatch from the table.
    for (int v = 0; v < 4; v++) begin
      do_start();
      send_byte(vecs[v].dev, ack, early);
      check($sformatf("v%0d_addr_ack", v), ack, vecs[v].exp_ack);
      if (vecs[v].exp_ack) check($sformatf("v%0d_ack_hold", v), early, 1'b1);
      check($sformatf("v%0d_busy", v), busy, vecs[v].exp_ack);
      send_byte(vecs[v].ptr, ack, early);
      check($sformatf("v%0d_ptr_ack", v), ack, vecs[v].exp_ack);
      for (int k = 0; k < vecs[v].nd; k++) begin
        a = vecs[v].ptr + 8'(k);
        d = (k == 0) ? vecs[v].d0 : vecs[v].d1;
        if (vecs[v].exp_ack) wr_exp.push_back({a, d});
        send_byte(d, ack, early);
        check($sformatf("v%0d_data%0d_ack", v, k), ack, vecs[v].exp_ack);
      end
      check($sformatf("v%0d_busy_pre_stop", v), busy, vecs[v].exp_ack);
      do_stop();
      w(10);
      check($sformatf("v%0d_busy_after_stop", v), busy, 1'b0);
      check($sformatf("v%0d_ptr_end", v), reg_addr, vecs[v].exp_ptr);
      check($sformatf("v%0d_writes_done", v), wr_exp.size(), 0);
    end

    // Read with repeated start: ACK, ACK, NACK.
    do_start();
    send_byte(8'hD6, ack, early); check("rd_addr_w_ack", ack, 1'b1);
    send_byte(8'h10, ack, early); check("rd_ptr_ack", ack, 1'b1);
    do_rstart();
    rd_exp.push_back(8'h10);
    send_byte(8'hD7, ack, early); check("rd_addr_r_ack", ack, 1'b1);
    rd_exp.push_back(8'h11);
    recv_byte(1'b1, rb); check("rd_byte0", rb, 8'hEF);
    rd_exp.push_back(8'h12);
    recv_byte(1'b1, rb); check("rd_byte1", rb, 8'hEE);
    recv_byte(1'b0, rb); check("rd_byte2", rb, 8'hED);
    w(30);
    check("rd_sda_released", sda, 1'b1);
    check("rd_busy_after_nack", busy, 1'b0);
    do_stop();
    check("rd_ptr_end", reg_addr, 8'h13);
    check("rd_reads_done", rd_exp.size(), 0);

    // Reset in the middle of read bit 4 (a driven 0 of 0xEF).
    do_start();
    send_byte(8'hD6, ack, early);
    send_byte(8'h10, ack, early);
    do_rstart();
    rd_exp.push_back(8'h10);
    send_byte(8'hD7, ack, early); check("mr_addr_ack", ack, 1'b1);
    for (int i = 0; i < 3; i++) read_bit(rb[0], early);
    w(12); m_low = 1'b0; w(28); scl_o = 1'b1; w(10);
    check("mr_sda_driven", sda, 1'b0);
    reset = 1'b1;
    w(1);
    check("mr_sda_released", sda, 1'b1);
    check("mr_reg_addr", reg_addr, 8'h00);
    check("mr_busy", busy, 1'b0);
    check("mr_strobes", {reg_write, reg_read}, 2'b00);
    check("mr_wdata", reg_wdata, 8'h00);
    reset = 1'b0;
    w(10); scl_o = 1'b0; w(40); scl_o = 1'b1; w(40);
    do_start();
    rd_exp.push_back(8'h00);
    send_byte(8'hD7, ack, early); check("mr2_addr_ack", ack, 1'b1);
    recv_byte(1'b0, rb); check("mr2_byte", rb, 8'hFF);
    do_stop();
    check("mr2_ptr_end", reg_addr, 8'h01);
    check("mr2_reads_done", rd_exp.size(), 0);

    // Two-clock SDA glitch with SCL high must not act as a START.
    m_low = 1'b1; w(2); m_low = 1'b0; w(20);
    scl_o = 1'b0;
    send_byte(8'hD6, ack, early);
    check("gl_no_ack", ack, 1'b0);
    check("gl_busy", busy, 1'b0);
    do_stop();

    // STOP after three data bits: no write, pointer from the first byte kept.
    do_start();
    send_byte(8'hD6, ack, early); check("sp_addr_ack", ack, 1'b1);
    send_byte(8'h40, ack, early); check("sp_ptr_ack", ack, 1'b1);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
    do_stop();
    w(10);
    check("sp_busy", busy, 1'b0);
    check("sp_ptr", reg_addr, 8'h40);
    check("sp_sda", sda, 1'b1);
    w(200);
    check("final_writes_empty", wr_exp.size(), 0);
    check("final_reads_empty", rd_exp.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1);
  end

endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (slave) responder for 7-bit addressing at standard/fast-mode rates, the bus counterpart to `i2c_master`. It oversamples SCL/SDA with the system clock, detects START/STOP, and ACKs its own address. It exposes an 8-bit register-pointer protocol to an external register file: the first written byte sets the pointer, later bytes write or read with auto-increment. It lets an FPGA design act as a peripheral on the same two-wire bus the master drives.

## Interface
- `ADDRESS`, `7'b1101011`: 7-bit target address matched against the first byte after START.
- `FILTER_CYCLES`, `4`: consecutive identical synchronized samples required before a filtered SCL/SDA level changes. Range 1–15.
- `HOLD_CYCLES`, `15`: clocks between detected SCL fall and any change of the SDA drive, giving data hold time. Range 1–255.

- `clk_in`  input  1  system clock, 48 MHz nominal.
- `reset`  input  1  synchronous, active-high reset.
- `scl`  input  1  bus clock, sampled only. This block never stretches SCL.
- `sda`  inout  1  open-drain data: driven `0` or `z`, never `1`.
- `reg_addr`  output  8  register pointer presented with `reg_write` and `reg_read`.
- `reg_wdata`  output  8  write data, valid while `reg_write` is high.
- `reg_write`  output  1  one-cycle write strobe.
- `reg_read`  output  1  one-cycle read request. `reg_rdata` is sampled on the following cycle.
- `reg_rdata`  input  8  register read data (synchronous-read RAM latency 1).
- `busy`  output  1  high from an address match until STOP, a NACKed read, or reset.

## Operation
- **Input conditioning**
  - SCL and SDA each pass through a 2-flop synchronizer and then a `FILTER_CYCLES` glitch filter.
  - Edge detects are taken on the filtered levels.
  - START: filtered SDA falls while filtered SCL is high.
  - STOP: filtered SDA rises while filtered SCL is high.
- **Sampling and driving**
  - Bits are sampled on filtered SCL rise, MSB first.
  - SDA drive changes only `HOLD_CYCLES` clocks after a filtered SCL fall.
- **States**
  - `IDLE`: SDA released. START → `ADDR`.
  - `ADDR`: shift in 8 bits.
    - On a match, go to `ADDR_ACK` and pull SDA low after the 8th SCL fall.
    - On a mismatch, go to `IGNORE`.
  - `ADDR_ACK`: release SDA after the 9th SCL fall.
    - If the R/W bit is 0 → `WR_BYTE`, with first_byte flag set.
    - If the R/W bit is 1 → `RD_BYTE`. `reg_read` pulses at the current pointer on the cycle of the 8th SCL rise, and the returned data is loaded into the TX shifter.
  - `WR_BYTE`: shift in 8 bits, then → `WR_ACK` and pull SDA low for the ACK.
    - If first_byte: pointer ← byte, clear first_byte.
    - Otherwise: on the 8th SCL rise cycle, `reg_write` pulses with `reg_addr` = pointer and `reg_wdata` = byte, then pointer increments.
  - `WR_ACK`: every write byte is ACKed. After the 9th SCL fall → `WR_BYTE`.
  - `RD_BYTE`: drive TX shifter bits.
    - Drive `0` where the bit is 0, release where it is 1.
    - The MSB is driven at the ACK's SCL fall + `HOLD_CYCLES`.
    - After 8 bits, release SDA → `RD_ACK`.
  - `RD_ACK`: sample master ACK on the 9th SCL rise.
    - ACK (SDA low): pointer increments, `reg_read` pulses at the new pointer, data is loaded into the TX shifter → `RD_BYTE`.
    - NACK: → `IGNORE`. The pointer still increments.
  - `IGNORE`: SDA released. Wait for START or STOP.
- **Global events**
  - START in any state → `ADDR` (repeated start) with bit counter cleared. Pointer is kept.
  - STOP in any state → `IDLE`.
  - START/STOP take priority over a bit sampled on the same cycle.
- **Pointer**
  - 8 bits, wraps 0xFF → 0x00.
  - Survives STOP. Cleared only by `reset`.
- `reg_addr` always shows the pointer.

## Timing
- **Reset values:** SDA released (`z`), `reg_addr`=0, `reg_wdata`=0, `reg_write`=0, `reg_read`=0, `busy`=0, state `IDLE`.
- **Reset mid-transfer:** SDA is released on the cycle after `reset` is sampled. The block ignores the bus until the next START.
- **Input latency:** pin to filtered level is 2 + `FILTER_CYCLES` clocks.
- **Strobes:** `reg_write` and `reg_read` are exactly one cycle and never high together.
- **Read data:** `reg_rdata` is captured the cycle after `reg_read`, well before the SCL fall that launches its MSB.
- **Minimum SCL low time:** (`HOLD_CYCLES` + 4) clocks. Below this, behaviour is undefined.
- **Throughput:** one byte per 9 SCL periods. There is no stretching.

## Test plan
- **Register write:** START, 0xD6, 0x08, 0xA5, 0x5A, STOP.
  - ACK on all four bytes.
  - `reg_write` at addr 0x08 with 0xA5, then at 0x09 with 0x5A.
  - Pointer ends at 0x0A and `busy` falls at STOP.
- **Read with repeated start:** START 0xD6 0x10, rSTART 0xD7, master reads 3 bytes (ACK, ACK, NACK), STOP. The model returns `addr ^ 0xFF`.
  - SDA bits are 0xEF, 0xEE, 0xED.
  - `reg_read` at 0x10, 0x11, 0x12.
  - SDA is released after the NACK.
- **Address mismatch:** START 0xA0 0x08 STOP.
  - SDA is never driven.
  - No strobes; pointer unchanged; `busy` stays 0.
- **Pointer wrap:** write pointer 0xFF, then data 0x11, 0x22.
  - Writes go to 0xFF and 0x00; pointer ends at 0x01.
- **Reset mid-read:** assert `reset` during bit 4 of a read byte.
  - SDA released next cycle; all outputs at reset values.
  - The following START 0xD7 reads from pointer 0x00.
- **Glitch rejection and STOP mid-byte:**
  - A 2-clock SDA low pulse while SCL is high (`FILTER_CYCLES`=4) causes no START.
  - STOP after 3 data bits of a write → `IDLE`, with no `reg_write`.
